// File: rtl/enemy_missle_ctl_pkg.sv
// Shared screen geometry, FSM state encoding and position helpers for the
// missile controllers and the draw stage.
package enemy_missle_ctl_pkg;

  localparam int POS_W = 12;
  localparam int CNT_W = 21;

  localparam int SCREEN_Y_LIMIT = 768;
  localparam int PLAYER_WIDTH   = 48;
  localparam int PLAYER_HEIGHT  = 64;
  localparam int MISSLE_WIDTH   = 4;
  localparam int MISSLE_HEIGHT  = 16;
  localparam int ENEMY_HEIGHT   = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLY    = 2'd1,
    ST_HIT    = 2'd2,
    ST_RELOAD = 2'd3
  } missle_state_t;

  // Positions are summed one bit wider; clamp back to the 12-bit screen range.
  function automatic logic [POS_W-1:0] sat_pos(input logic [POS_W:0] v);
    return v[POS_W] ? {POS_W{1'b1}} : v[POS_W-1:0];
  endfunction

endpackage

// File: rtl/enemy_missle_ctl_rect_overlap.sv
// Axis-aligned rectangle overlap test; sums are one bit wider than the
// positions so edges near 4095 never wrap.
module rect_overlap
  import enemy_missle_ctl_pkg::*;
#(
  parameter int A_W = MISSLE_WIDTH,
  parameter int A_H = MISSLE_HEIGHT,
  parameter int B_W = PLAYER_WIDTH,
  parameter int B_H = PLAYER_HEIGHT
) (
  input  logic [POS_W-1:0] a_x,
  input  logic [POS_W-1:0] a_y,
  input  logic [POS_W-1:0] b_x,
  input  logic [POS_W-1:0] b_y,
  output logic             overlap
);

  localparam logic [POS_W:0] AW = A_W[POS_W:0];
  localparam logic [POS_W:0] AH = A_H[POS_W:0];
  localparam logic [POS_W:0] BW = B_W[POS_W:0];
  localparam logic [POS_W:0] BH = B_H[POS_W:0];

  logic [POS_W:0] a_x_e;
  logic [POS_W:0] a_y_e;
  logic [POS_W:0] b_x_e;
  logic [POS_W:0] b_y_e;

  assign a_x_e = {1'b0, a_x};
  assign a_y_e = {1'b0, a_y};
  assign b_x_e = {1'b0, b_x};
  assign b_y_e = {1'b0, b_y};

  assign overlap = (a_x_e < b_x_e + BW) && (b_x_e < a_x_e + AW) &&
                   (a_y_e < b_y_e + BH) && (b_y_e < a_y_e + AH);

endmodule

// File: rtl/enemy_missle_ctl.sv
// Enemy missile controller: launches from the firing enemy, descends one
// pixel every COUNTER_LIMIT+1 cycles, reports a player hit, then reloads.
//
// state     | meaning
// ST_IDLE   | no missile; a sampled fire launches
// ST_FLY    | missile visible and descending; checks player and screen bottom
// ST_HIT    | one-cycle hit pulse, missile hidden
// ST_RELOAD | cooldown of RELOAD_CYCLES cycles, fire ignored
module enemy_missle_ctl
  import enemy_missle_ctl_pkg::*;
#(
  parameter int COUNTER_LIMIT = 90000,
  parameter int RELOAD_CYCLES = 1000,
  parameter int MISSLE_W      = MISSLE_WIDTH,
  parameter int MISSLE_H      = MISSLE_HEIGHT,
  parameter int ENEMY_H       = ENEMY_HEIGHT,
  parameter int PLAYER_W      = PLAYER_WIDTH,
  parameter int PLAYER_H      = PLAYER_HEIGHT,
  parameter int Y_LIMIT       = SCREEN_Y_LIMIT
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             fire,
  input  logic [POS_W-1:0] xpos_in,
  input  logic [POS_W-1:0] ypos_in,
  input  logic [POS_W-1:0] player_xpos,
  input  logic [POS_W-1:0] player_ypos,
  output logic [POS_W-1:0] xpos_out,
  output logic [POS_W-1:0] ypos_out,
  output logic             on_out,
  output logic             busy,
  output logic             hit
);

  localparam int             RELOAD_LAST = RELOAD_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_STEP  = COUNTER_LIMIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_RELOAD = RELOAD_LAST[CNT_W-1:0];
  localparam logic [POS_W:0] ENEMY_H_X  = ENEMY_H[POS_W:0];
  localparam logic [POS_W:0] MISSLE_H_X = MISSLE_H[POS_W:0];
  localparam logic [POS_W:0] Y_LIMIT_X  = Y_LIMIT[POS_W:0];

  missle_state_t    state;
  logic [CNT_W-1:0] counter;
  logic [POS_W:0]   launch_y;
  logic [POS_W:0]   next_y;
  logic [POS_W:0]   bottom_y;
  logic             at_bottom;
  logic             overlap;

  assign launch_y  = {1'b0, ypos_in} + ENEMY_H_X;
  assign next_y    = {1'b0, ypos_out} + {{POS_W{1'b0}}, 1'b1};
  assign bottom_y  = {1'b0, ypos_out} + MISSLE_H_X;
  assign at_bottom = (bottom_y >= Y_LIMIT_X);

  rect_overlap #(
    .A_W(MISSLE_W),
    .A_H(MISSLE_H),
    .B_W(PLAYER_W),
    .B_H(PLAYER_H)
  ) u_overlap (
    .a_x    (xpos_out),
    .a_y    (ypos_out),
    .b_x    (player_xpos),
    .b_y    (player_ypos),
    .overlap(overlap)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      counter  <= '0;
      xpos_out <= '0;
      ypos_out <= '0;
      on_out   <= 1'b0;
      busy     <= 1'b0;
      hit      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          on_out <= 1'b0;
          busy   <= 1'b0;
          hit    <= 1'b0;
          if (fire) begin
            state    <= ST_FLY;
            xpos_out <= xpos_in;
            ypos_out <= sat_pos(launch_y);
            counter  <= '0;
            on_out   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FLY: begin
          // A strike wins over reaching the bottom in the same cycle.
          if (overlap) begin
            state   <= ST_HIT;
            hit     <= 1'b1;
            on_out  <= 1'b0;
            counter <= '0;
          end else if (at_bottom) begin
            state   <= ST_RELOAD;
            on_out  <= 1'b0;
            counter <= '0;
          end else if (counter == CNT_STEP) begin
            counter  <= '0;
            ypos_out <= sat_pos(next_y);
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ST_HIT: begin
          hit     <= 1'b0;
          state   <= ST_RELOAD;
          counter <= '0;
        end
        ST_RELOAD: begin
          if (counter == CNT_RELOAD) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= '0;
          on_out  <= 1'b0;
          busy    <= 1'b0;
          hit     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_missle_ctl.sv
// Scoreboard bench for enemy_missle_ctl: flights are predicted from launch and
// player positions, then compared when the DUT drops busy.
module tb_enemy_missle_ctl;

  localparam int CL = 3;
  localparam int RC = 5;
  localparam int YL = 768;
  localparam int MW = 4;
  localparam int MH = 16;
  localparam int PW = 48;
  localparam int PH = 64;
  localparam int EH = 64;

  logic        pclk;
  logic        rst_n;
  logic        fire;
  logic [11:0] xpos_in, ypos_in, player_xpos, player_ypos;
  logic [11:0] xpos_out, ypos_out;
  logic        on_out, busy, hit;

  enemy_missle_ctl #(
    .COUNTER_LIMIT(CL),
    .RELOAD_CYCLES(RC),
    .Y_LIMIT      (YL)
  ) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .fire       (fire),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .player_xpos(player_xpos),
    .player_ypos(player_ypos),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out),
    .on_out     (on_out),
    .busy       (busy),
    .hit        (hit)
  );

  typedef struct {
    int l;
    int x;
    int y0;
    int yend;
    bit hit;
    int t;
    int busy_fall;
    int y4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   free_at = 0;
  int   n_push = 0;
  int   n_pop = 0;
  bit   mon_en = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: run still active at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the missile down a pixel at a time until it meets the
  // player or the screen bottom; each pixel costs CL+1 cycles.
  function automatic exp_t predict(input int l, input int x, input int y,
                                   input int px, input int py);
    exp_t e;
    int   yy;
    yy = y + EH;
    if (yy > 4095) yy = 4095;
    e.l = l; e.x = x; e.y0 = yy; e.hit = 0;
    while (1) begin
      if (x < px + PW && px < x + MW && yy < py + PH && py < yy + MH) begin
        e.hit = 1;
        break;
      end
      if (yy + MH >= YL) break;
      yy++;
    end
    e.yend = yy;
    e.t = l + (yy - e.y0) * (CL + 1) + 1;
    e.busy_fall = e.t + (e.hit ? 1 : 0) + RC;
    e.y4 = (yy > e.y0) ? e.y0 + 1 : -1;
    return e;
  endfunction

  task automatic do_launch(input int x, input int y, input int px, input int py,
                           input bit noise, input bit hold);
    exp_t e;
    while (cyc + 1 < free_at) begin
      if (noise) begin
        fire    = 1'($urandom);
        xpos_in = 12'($urandom);
        ypos_in = 12'($urandom);
      end
      @(negedge pclk);
    end
    xpos_in = 12'(x); ypos_in = 12'(y);
    player_xpos = 12'(px); player_ypos = 12'(py);
    fire = 1'b1;
    e = predict(cyc + 1, x, y, px, py);
    sb.push_back(e);
    n_push++;
    free_at = e.busy_fall + 1;
    @(negedge pclk);
    if (!hold) fire = 1'b0;
    if (noise) begin
      xpos_in = 12'($urandom);
      ypos_in = 12'($urandom);
    end
  endtask

  // Fire pulses during the cooldown must not be remembered.
  task automatic idle_gap(input int n);
    while (cyc + 1 < free_at) begin
      fire = 1'($urandom);
      @(negedge pclk);
    end
    fire = 1'b0;
    repeat (n) begin
      @(negedge pclk);
      chk("idle_no_launch", {on_out, busy}, 0);
    end
    free_at = cyc + 1;
  endtask

  // Monitor
  int   rise_cyc, rise_x, rise_y, fall_cyc, fall_y, hit_cnt, hit_cyc, y4_act;
  bit   hit_on, x_moved, prev_on, prev_busy;

  always @(negedge pclk) begin
    if (!rst_n || !mon_en) begin
      prev_on = 0; prev_busy = 0; hit_cnt = 0; hit_on = 0; x_moved = 0;
    end else begin
      if (on_out && !prev_on) begin
        rise_cyc = cyc; rise_x = int'(xpos_out); rise_y = int'(ypos_out);
        x_moved = 0; hit_cnt = 0; hit_on = 0; y4_act = -1;
      end
      if (on_out && prev_on && int'(xpos_out) != rise_x) x_moved = 1;
      if (on_out && cyc == rise_cyc + CL + 1) y4_act = int'(ypos_out);
      if (!on_out && prev_on) begin
        fall_cyc = cyc; fall_y = int'(ypos_out);
      end
      if (hit) begin
        hit_cnt++; hit_cyc = cyc; hit_on = on_out;
      end
      if (!busy && prev_busy) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: flight ended at cycle %0d, none expected", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_pop++;
          chk("launch_cycle", rise_cyc, e.l);
          chk("launch_x", rise_x, e.x);
          chk("launch_y", rise_y, e.y0);
          chk("x_held", x_moved, 0);
          if (e.y4 >= 0) chk("first_step_y", y4_act, e.y4);
          chk("on_fall_cycle", fall_cyc, e.t);
          chk("end_y", fall_y, e.yend);
          chk("hit_pulses", hit_cnt, e.hit);
          if (e.hit) begin
            chk("hit_cycle", hit_cyc, e.t);
            chk("hit_while_on", hit_on, 0);
          end
          chk("busy_fall_cycle", cyc, e.busy_fall);
        end
      end
      prev_on = on_out;
      prev_busy = busy;
    end
  end

  initial begin
    rst_n = 1'b0; fire = 1'b0;
    xpos_in = '0; ypos_in = '0; player_xpos = 12'd1000; player_ypos = 12'd100;
    #3;
    chk("rst_xpos", xpos_out, 0);
    chk("rst_ypos", ypos_out, 0);
    chk("rst_on", on_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    mon_en = 1;
    free_at = cyc + 2;

    do_launch(100, 50, 1000, 100, 0, 0);   // plain flight to the bottom
    do_launch(100, 50, 90, 300, 0, 0);     // hit at y=285
    do_launch(100, 600, 500, 700, 0, 0);   // miss, bottom at y=752
    do_launch(200, 650, 600, 100, 0, 1);   // fire held: back-to-back launches
    do_launch(200, 650, 600, 100, 0, 1);
    do_launch(200, 650, 600, 100, 0, 0);
    idle_gap(6);
    do_launch(100, 700, 98, 730, 0, 0);    // overlap and bottom together
    do_launch(300, 760, 0, 0, 0, 0);       // launched past the bottom
    do_launch(4094, 4050, 4080, 4080, 0, 0); // near 4095: no wrap
    do_launch(100, 600, 104, 620, 0, 0);   // x edges touch: no hit
    do_launch(100, 600, 103, 620, 0, 0);
    do_launch(100, 600, 52, 620, 0, 0);
    do_launch(100, 600, 53, 620, 0, 0);
    idle_gap(4);

    // Reset in mid-flight between clock edges
    while (cyc + 1 < free_at) @(negedge pclk);
    @(negedge pclk);
    mon_en = 0;
    xpos_in = 12'd100; ypos_in = 12'd50; player_xpos = 12'd1000; player_ypos = 12'd100;
    fire = 1'b1;
    @(negedge pclk);
    fire = 1'b0;
    repeat (20) @(negedge pclk);
    chk("pre_rst_on", on_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_xpos", xpos_out, 0);
    chk("midrst_ypos", ypos_out, 0);
    chk("midrst_on", on_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hit", hit, 0);
    @(negedge pclk);
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge pclk);
      chk("post_rst_idle", {on_out, busy, hit}, 0);
    end
    free_at = cyc + 1;
    mon_en = 1;

    for (int i = 0; i < 20; i++) begin
      int x, px;
      x  = $urandom_range(60, 1100);
      px = x - 52 + $urandom_range(0, 60);
      do_launch(x, $urandom_range(560, 760), px, $urandom_range(600, 780), 1, 0);
      if (i % 5 == 4) idle_gap(3);
    end

    fire = 1'b0;
    while (cyc < free_at + 2) @(negedge pclk);
    chk("sb_drained", sb.size(), 0);
    chk("flights_seen", n_pop, n_push);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
